// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier (IDLE -> RUN -> DONE) producing a 2*WIDTH signed product on HI/LO.
// Define MULT_UNSIGNED_EN to add the unsigned_op port (MULTU support, one extra step in both modes).
module booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef MULT_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  input  logic             mult_in,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             mult_out
);

`ifdef MULT_UNSIGNED_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  // One guard bit on the accumulator keeps -M representable for the most-negative multiplicand.
  localparam int AW      = EW + 1;
  localparam int N_STEPS = EW;
  localparam int CW      = $clog2(N_STEPS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [EW-1:0]   m;
  logic [AW-1:0]   acc;
  logic [EW-1:0]   q;
  logic            q_1;
  logic [CW-1:0]   count;

  logic [EW-1:0]   a_ext;
  logic [EW-1:0]   b_ext;
  logic [AW-1:0]   m_ext;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   step_acc;
  logic [EW-1:0]   step_q;

`ifdef MULT_UNSIGNED_EN
  assign a_ext = {~unsigned_op & A[WIDTH-1], A};
  assign b_ext = {~unsigned_op & B[WIDTH-1], B};
`else
  assign a_ext = A;
  assign b_ext = B;
`endif

  // NOTE: every always_comb output gets a value on every path; a missing default infers a latch.
  always_comb begin
    m_ext = {m[EW-1], m};
    case ({q[0], q_1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
    step_acc = {sum[AW-1], sum[AW-1:1]};
    step_q   = {sum[0], q[EW-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      m        <= '0;
      acc      <= '0;
      q        <= '0;
      q_1      <= 1'b0;
      count    <= '0;
      HI       <= '0;
      LO       <= '0;
      mult_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mult_out <= 1'b0;
          if (mult_in) begin
            m     <= a_ext;
            acc   <= '0;
            q     <= b_ext;
            q_1   <= 1'b0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= step_acc;
          q     <= step_q;
          q_1   <= q[0];
          count <= count + CW'(1);
          if (count == CW'(N_STEPS - 1)) begin
            // Product occupies the low 2*WIDTH bits of {acc, q}; the guard bit is discarded.
`ifdef MULT_UNSIGNED_EN
            HI <= {step_acc[WIDTH-2:0], step_q[WIDTH]};
            LO <= step_q[WIDTH-1:0];
`else
            HI <= step_acc[WIDTH-1:0];
            LO <= step_q;
`endif
            mult_out <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          mult_out <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          mult_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
